// File: rtl/btn_debounce_select.sv
`default_nettype none
// ============================================================================
//  Module   : btn_debounce_select
//  Brief    : Push-button synchroniser/debouncer with press/release pulses and
//             a sticky one-hot operation select (priority C > U > D > L > R).
//  Revision : 1.0 - initial release
// ============================================================================
module btn_debounce_select #(
  parameter int NUM_BTN         = 5,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] BTN_RAW,
  output logic [NUM_BTN-1:0] BTN_CLEAN,
  output logic [NUM_BTN-1:0] BTN_PRESS,
  output logic [NUM_BTN-1:0] BTN_RELEASE,
  output logic [NUM_BTN-1:0] SEL_ONEHOT,
  output logic               SEL_VALID
);

  localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    W_HIGH = 2'd1,
    S_HIGH = 2'd2,
    W_LOW  = 2'd3
  } state_t;

  logic [NUM_BTN-1:0] w_clean;
  logic [NUM_BTN-1:0] w_press;
  logic [NUM_BTN-1:0] w_release;
  logic [NUM_BTN-1:0] w_sel_nxt;
  logic [NUM_BTN-1:0] r_sel;
  logic               r_valid;

  generate
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      logic [SYNC_STAGES-1:0] r_sync;
      logic                   w_s;
      state_t                 r_state;
      state_t                 w_state_nxt;
      logic [c_CNT_W-1:0]     r_cnt;
      logic [c_CNT_W-1:0]     w_cnt_nxt;
      logic                   r_press;
      logic                   r_release;
      logic                   w_press_nxt;
      logic                   w_release_nxt;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_sync <= '0;
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], BTN_RAW[gi]};
        end
      end

      assign w_s = r_sync[SYNC_STAGES-1];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_state   <= S_LOW;
          r_cnt     <= '0;
          r_press   <= 1'b0;
          r_release <= 1'b0;
        end else begin
          r_state   <= w_state_nxt;
          r_cnt     <= w_cnt_nxt;
          r_press   <= w_press_nxt;
          r_release <= w_release_nxt;
        end
      end

      always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        case (r_state)
          S_LOW: begin
            if (w_s) begin
              w_state_nxt = W_HIGH;
              w_cnt_nxt   = '0;
            end
          end
          W_HIGH: begin
            if (!w_s) begin
              w_state_nxt = S_LOW;
              w_cnt_nxt   = '0;
            end else if (r_cnt == c_CNT_MAX) begin
              w_state_nxt = S_HIGH;
              w_cnt_nxt   = '0;
              w_press_nxt = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end
          S_HIGH: begin
            if (!w_s) begin
              w_state_nxt = W_LOW;
              w_cnt_nxt   = '0;
            end
          end
          W_LOW: begin
            if (w_s) begin
              w_state_nxt = S_HIGH;
              w_cnt_nxt   = '0;
            end else if (r_cnt == c_CNT_MAX) begin
              w_state_nxt   = S_LOW;
              w_cnt_nxt     = '0;
              w_release_nxt = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end
          default: begin
            w_state_nxt = S_LOW;
            w_cnt_nxt   = '0;
          end
        endcase
      end

      // Clean level is high while accepted-high, including while a fall is pending.
      assign w_clean[gi]   = (r_state == S_HIGH) || (r_state == W_LOW);
      assign w_press[gi]   = r_press;
      assign w_release[gi] = r_release;
    end
  endgenerate

  // Isolate the lowest set bit: index 0 (C) has the highest priority.
  assign w_sel_nxt = w_press & (~w_press + NUM_BTN'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel   <= '0;
      r_valid <= 1'b0;
    end else if (|w_press) begin
      r_sel   <= w_sel_nxt;
      r_valid <= 1'b1;
    end
  end

  assign BTN_CLEAN   = w_clean;
  assign BTN_PRESS   = w_press;
  assign BTN_RELEASE = w_release;
  assign SEL_ONEHOT  = r_sel;
  assign SEL_VALID   = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_btn_debounce_select.sv
`default_nettype none
// ============================================================================
//  Module   : tb_btn_debounce_select
//  Brief    : Directed, table-driven bench for btn_debounce_select.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_btn_debounce_select;

  localparam int NUM_BTN = 5;

  logic               clk;
  logic               reset;
  logic [NUM_BTN-1:0] BTN_RAW;
  logic [NUM_BTN-1:0] BTN_CLEAN;
  logic [NUM_BTN-1:0] BTN_PRESS;
  logic [NUM_BTN-1:0] BTN_RELEASE;
  logic [NUM_BTN-1:0] SEL_ONEHOT;
  logic               SEL_VALID;

  int checks = 0;
  int errors = 0;

  btn_debounce_select #(
    .NUM_BTN         (NUM_BTN),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .BTN_RAW     (BTN_RAW),
    .BTN_CLEAN   (BTN_CLEAN),
    .BTN_PRESS   (BTN_PRESS),
    .BTN_RELEASE (BTN_RELEASE),
    .SEL_ONEHOT  (SEL_ONEHOT),
    .SEL_VALID   (SEL_VALID)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] raw;
    int         n;
    logic [4:0] clean;
    logic [4:0] press;
    logic [4:0] rel;
    logic [4:0] sel;
    logic       valid;
  } vec_t;

  vec_t tbl [20];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [4:0] c, input logic [4:0] p,
                         input logic [4:0] r, input logic [4:0] s, input logic v);
    chk({tag, ".clean"},   BTN_CLEAN,   c);
    chk({tag, ".press"},   BTN_PRESS,   p);
    chk({tag, ".release"}, BTN_RELEASE, r);
    chk({tag, ".sel"},     SEL_ONEHOT,  s);
    chk({tag, ".valid"},   {4'b0, SEL_VALID}, {4'b0, v});
  endtask

  initial begin
    // raw, hold cycles, clean, press, release, sel, valid (sampled after the last hold cycle)
    tbl[0]  = '{5'b00010, 6,  5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0};
    tbl[1]  = '{5'b00010, 1,  5'b00010, 5'b00010, 5'b00000, 5'b00000, 1'b0};
    tbl[2]  = '{5'b00010, 1,  5'b00010, 5'b00000, 5'b00000, 5'b00010, 1'b1};
    tbl[3]  = '{5'b01010, 1,  5'b00010, 5'b00000, 5'b00000, 5'b00010, 1'b1};
    tbl[4]  = '{5'b00010, 1,  5'b00010, 5'b00000, 5'b00000, 5'b00010, 1'b1};
    tbl[5]  = '{5'b01010, 1,  5'b00010, 5'b00000, 5'b00000, 5'b00010, 1'b1};
    tbl[6]  = '{5'b00010, 10, 5'b00010, 5'b00000, 5'b00000, 5'b00010, 1'b1};
    tbl[7]  = '{5'b10011, 6,  5'b00010, 5'b00000, 5'b00000, 5'b00010, 1'b1};
    tbl[8]  = '{5'b10011, 1,  5'b10011, 5'b10001, 5'b00000, 5'b00010, 1'b1};
    tbl[9]  = '{5'b10011, 1,  5'b10011, 5'b00000, 5'b00000, 5'b00001, 1'b1};
    tbl[10] = '{5'b10010, 6,  5'b10011, 5'b00000, 5'b00000, 5'b00001, 1'b1};
    tbl[11] = '{5'b10010, 1,  5'b10010, 5'b00000, 5'b00001, 5'b00001, 1'b1};
    tbl[12] = '{5'b10010, 1,  5'b10010, 5'b00000, 5'b00000, 5'b00001, 1'b1};
    tbl[13] = '{5'b00000, 7,  5'b00000, 5'b00000, 5'b10010, 5'b00001, 1'b1};
    tbl[14] = '{5'b00000, 1,  5'b00000, 5'b00000, 5'b00000, 5'b00001, 1'b1};
    tbl[15] = '{5'b01000, 7,  5'b01000, 5'b01000, 5'b00000, 5'b00001, 1'b1};
    tbl[16] = '{5'b01000, 1,  5'b01000, 5'b00000, 5'b00000, 5'b01000, 1'b1};
    tbl[17] = '{5'b00010, 7,  5'b00010, 5'b00010, 5'b01000, 5'b01000, 1'b1};
    tbl[18] = '{5'b00010, 1,  5'b00010, 5'b00000, 5'b00000, 5'b00010, 1'b1};
    tbl[19] = '{5'b00000, 8,  5'b00000, 5'b00000, 5'b00000, 5'b00010, 1'b1};

    reset   = 1'b1;
    BTN_RAW = '0;
    step();
    step();
    chk_all("reset", 5'b0, 5'b0, 5'b0, 5'b0, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      step();
      chk_all($sformatf("idle%0d", i), 5'b0, 5'b0, 5'b0, 5'b0, 1'b0);
    end

    for (int v = 0; v < 20; v++) begin
      BTN_RAW = tbl[v].raw;
      for (int k = 0; k < tbl[v].n; k++) step();
      chk_all($sformatf("vec%0d", v), tbl[v].clean, tbl[v].press, tbl[v].rel,
              tbl[v].sel, tbl[v].valid);
    end

    // Reset two cycles before BTN2 would be accepted, raw level kept high.
    BTN_RAW = 5'b00100;
    for (int k = 0; k < 5; k++) step();
    chk_all("pre_rst", 5'b0, 5'b0, 5'b0, 5'b00010, 1'b1);
    reset = 1'b1;
    #1;
    chk_all("in_rst0", 5'b0, 5'b0, 5'b0, 5'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_all($sformatf("in_rst%0d", k + 1), 5'b0, 5'b0, 5'b0, 5'b0, 1'b0);
    end
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk_all($sformatf("post_rst%0d", k), 5'b0, 5'b0, 5'b0, 5'b0, 1'b0);
    end
    step();
    chk_all("post_rst_acc", 5'b00100, 5'b00100, 5'b0, 5'b0, 1'b0);
    step();
    chk_all("post_rst_sel", 5'b00100, 5'b0, 5'b0, 5'b00100, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
